// File: rtl/hermes_rx_stamp_fifo_if.sv
// ----------------------------------------------------------------------------
// hermes_rx_stamp_fifo_if
//   Bundles the Hermes receive handshake, the downstream flit handshake and the
//   timestamp queue handshake of hermes_rx_stamp_fifo.
//
//   master : router + downstream consumer side (drives rx/data/ack/pop/tick)
//   slave  : the stamp FIFO itself
//
//   Signals
//     tick_counter_i  free-running system tick
//     rx_i/eop_i/data_i, credit_o        router -> block flit handshake
//     tx_o/eop_o/data_o, ack_i           block -> consumer flit handshake
//     ts_valid_o/ts_o/ts_head_o, ts_pop_i  per-packet timestamp queue
//     pkt_count_o                        stamped packets queued
// ----------------------------------------------------------------------------
interface hermes_rx_stamp_fifo_if #(
    parameter int FLIT_SIZE = 32,
    parameter int PKT_DEPTH = 4
);
    localparam int CW = $clog2(PKT_DEPTH) + 1;

    logic [31:0]          tick_counter_i;
    logic                 rx_i;
    logic                 eop_i;
    logic                 credit_o;
    logic [FLIT_SIZE-1:0] data_i;
    logic                 tx_o;
    logic                 eop_o;
    logic                 ack_i;
    logic [FLIT_SIZE-1:0] data_o;
    logic                 ts_valid_o;
    logic [31:0]          ts_o;
    logic                 ts_pop_i;
    logic [31:0]          ts_head_o;
    logic [CW-1:0]        pkt_count_o;

    modport master (
        output tick_counter_i, rx_i, eop_i, data_i, ack_i, ts_pop_i,
        input  credit_o, tx_o, eop_o, data_o, ts_valid_o, ts_o, ts_head_o,
               pkt_count_o
    );

    modport slave (
        input  tick_counter_i, rx_i, eop_i, data_i, ack_i, ts_pop_i,
        output credit_o, tx_o, eop_o, data_o, ts_valid_o, ts_o, ts_head_o,
               pkt_count_o
    );
endinterface

// File: rtl/hermes_rx_stamp_fifo.sv
// ----------------------------------------------------------------------------
// hermes_rx_stamp_fifo
//   Receive buffer between the Hermes router local output and the DMNI Hermes
//   input. Flits are queued in a BUFFER_SIZE-deep FIFO; every accepted EOP flit
//   also pushes the current tick into a PKT_DEPTH-deep timestamp queue. The
//   consumer pops one timestamp per packet once it is done with that packet.
//
//   Optional feature (macro HERMES_RX_STAMP_HEAD_EN): a second queue holds the
//   tick of each packet's first flit, committed alongside the EOP stamp and
//   presented on ts_head_o. Without the macro ts_head_o is tied to zero.
//
//   Ports
//     clk_i  clock
//     rst_i  asynchronous reset, active high
//     bus    hermes_rx_stamp_fifo_if.slave (flit + timestamp handshakes)
//
//   BUFFER_SIZE and PKT_DEPTH must be powers of two, >= 2, so pointers wrap
//   naturally; counts are one bit wider than pointers.
// ----------------------------------------------------------------------------
module hermes_rx_stamp_fifo #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 16,
    parameter int PKT_DEPTH   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    hermes_rx_stamp_fifo_if.slave  bus
);
    localparam int FW = $clog2(BUFFER_SIZE);
    localparam int PW = $clog2(PKT_DEPTH);

    localparam logic [FW:0] FLIT_FULL = (FW+1)'(BUFFER_SIZE);
    localparam logic [PW:0] PKT_FULL  = (PW+1)'(PKT_DEPTH);

    typedef struct packed {
        logic                 eop;
        logic [FLIT_SIZE-1:0] data;
    } flit_t;

    // ------------------------------------------------------------------------
    // Flit FIFO state
    // ------------------------------------------------------------------------
    flit_t         flit_mem [BUFFER_SIZE];
    logic [FW-1:0] wr_ptr;
    logic [FW-1:0] rd_ptr;
    logic [FW:0]   flit_count;

    // ------------------------------------------------------------------------
    // Timestamp queue state
    // ------------------------------------------------------------------------
    logic [31:0]   ts_mem [PKT_DEPTH];
    logic [PW-1:0] ts_wr_ptr;
    logic [PW-1:0] ts_rd_ptr;
    logic [PW:0]   ts_count;

    logic credit;
    logic tx;
    logic ts_valid;
    logic accept;
    logic pop;
    logic ts_push;
    logic ts_pop;

    // A full stamp queue holds off every flit, even mid-packet: we would have
    // nowhere to put the next EOP stamp and checking per-flit is not worth it.
    assign credit   = (flit_count != FLIT_FULL) && (ts_count != PKT_FULL);
    assign tx       = (flit_count != '0);
    assign ts_valid = (ts_count != '0);

    assign accept  = bus.rx_i && credit;
    assign pop     = tx && bus.ack_i;
    assign ts_push = accept && bus.eop_i;
    assign ts_pop  = ts_valid && bus.ts_pop_i;

    // ------------------------------------------------------------------------
    // Flit storage (no reset needed: outputs are gated by tx)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (accept) begin
            flit_mem[wr_ptr] <= '{eop: bus.eop_i, data: bus.data_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            flit_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   flit_count <= flit_count + 1'b1;
                2'b01:   flit_count <= flit_count - 1'b1;
                default: flit_count <= flit_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // EOP timestamp queue
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (ts_push) begin
            ts_mem[ts_wr_ptr] <= bus.tick_counter_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_wr_ptr <= '0;
            ts_rd_ptr <= '0;
            ts_count  <= '0;
        end else begin
            if (ts_push) ts_wr_ptr <= ts_wr_ptr + 1'b1;
            if (ts_pop)  ts_rd_ptr <= ts_rd_ptr + 1'b1;
            case ({ts_push, ts_pop})
                2'b10:   ts_count <= ts_count + 1'b1;
                2'b01:   ts_count <= ts_count - 1'b1;
                default: ts_count <= ts_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional header-arrival queue
    // ------------------------------------------------------------------------
`ifdef HERMES_RX_STAMP_HEAD_EN
    logic [31:0] head_mem [PKT_DEPTH];
    logic        in_packet;
    logic [31:0] head_tick;
    logic [31:0] head_stamp;

    // A packet whose first accepted flit is also its EOP never sets
    // in_packet, so it takes the live tick and both queues get the same value.
    assign head_stamp = in_packet ? head_tick : bus.tick_counter_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            in_packet <= 1'b0;
            head_tick <= '0;
        end else if (accept) begin
            if (!in_packet) head_tick <= bus.tick_counter_i;
            in_packet <= !bus.eop_i;
        end
    end

    // The head tick is only committed with the EOP stamp, so an incomplete
    // packet never occupies a slot and the two queues stay index-aligned.
    always_ff @(posedge clk_i) begin
        if (ts_push) begin
            head_mem[ts_wr_ptr] <= head_stamp;
        end
    end

    assign bus.ts_head_o = ts_valid ? head_mem[ts_rd_ptr] : 32'h0;
`else
    assign bus.ts_head_o = 32'h0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    flit_t head_flit;

    always_comb begin
        head_flit = '0;
        if (tx) head_flit = flit_mem[rd_ptr];
    end

    assign bus.credit_o    = credit;
    assign bus.tx_o        = tx;
    assign bus.eop_o       = head_flit.eop;
    assign bus.data_o      = head_flit.data;
    assign bus.ts_valid_o  = ts_valid;
    assign bus.ts_o        = ts_valid ? ts_mem[ts_rd_ptr] : 32'h0;
    assign bus.pkt_count_o = ts_count;

endmodule

// File: tb/tb_hermes_rx_stamp_fifo.sv
// ----------------------------------------------------------------------------
// tb_hermes_rx_stamp_fifo
//   Directed test of hermes_rx_stamp_fifo at default parameters
//   (FLIT_SIZE=32, BUFFER_SIZE=16, PKT_DEPTH=4). Inputs change 1 time unit
//   after the rising edge; outputs are checked at that same point.
// ----------------------------------------------------------------------------
module tb_hermes_rx_stamp_fifo;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    hermes_rx_stamp_fifo_if #(.FLIT_SIZE(32), .PKT_DEPTH(4)) bus ();

    hermes_rx_stamp_fifo #(
        .FLIT_SIZE  (32),
        .BUFFER_SIZE(16),
        .PKT_DEPTH  (4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

`ifdef HERMES_RX_STAMP_HEAD_EN
    localparam bit HEAD_EN = 1'b1;
`else
    localparam bit HEAD_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.rx_i           = 1'b0;
        bus.eop_i          = 1'b0;
        bus.data_i         = '0;
        bus.ack_i          = 1'b0;
        bus.ts_pop_i       = 1'b0;
        bus.tick_counter_i = '0;
    endtask

    task automatic send(input logic [31:0] d, input logic e, input logic [31:0] t);
        bus.rx_i           = 1'b1;
        bus.data_i         = d;
        bus.eop_i          = e;
        bus.tick_counter_i = t;
    endtask

    initial begin
        logic [31:0] exp_d;
        idle();

        // --- power-on reset -------------------------------------------------
        repeat (2) step();
        rst_i = 1'b0;
        #1;
        chk("rst_credit",   32'(bus.credit_o),    32'd1);
        chk("rst_tx",       32'(bus.tx_o),        32'd0);
        chk("rst_eop",      32'(bus.eop_o),       32'd0);
        chk("rst_data",     bus.data_o,           32'd0);
        chk("rst_ts_valid", 32'(bus.ts_valid_o),  32'd0);
        chk("rst_ts",       bus.ts_o,             32'd0);
        chk("rst_ts_head",  bus.ts_head_o,        32'd0);
        chk("rst_pkt",      32'(bus.pkt_count_o), 32'd0);

        // --- reset with 3 buffered flits of an unfinished packet -------------
        for (int i = 0; i < 3; i++) begin
            send(32'h11 + 32'(i), 1'b0, 32'd50);
            step();
        end
        idle();
        chk("pre_rst_tx",   32'(bus.tx_o), 32'd1);
        chk("pre_rst_data", bus.data_o,    32'h11);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_rst_tx",       32'(bus.tx_o),        32'd0);
        chk("mid_rst_credit",   32'(bus.credit_o),    32'd1);
        chk("mid_rst_pkt",      32'(bus.pkt_count_o), 32'd0);
        chk("mid_rst_ts_valid", 32'(bus.ts_valid_o),  32'd0);

        // --- 4-flit packet on ticks 100..103, streaming out with ack --------
        bus.ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(32'hA0 + 32'(k), (k == 3), 32'd100 + 32'(k));
            step();
            chk("pkt4_data", bus.data_o,      32'hA0 + 32'(k));
            chk("pkt4_eop",  32'(bus.eop_o),  32'(k == 3));
            if (k < 3) chk("pkt4_ts_early", 32'(bus.ts_valid_o), 32'd0);
        end
        bus.rx_i  = 1'b0;
        bus.eop_i = 1'b0;
        chk("pkt4_ts_valid", 32'(bus.ts_valid_o),  32'd1);
        chk("pkt4_ts",       bus.ts_o,             32'd103);
        chk("pkt4_ts_head",  bus.ts_head_o,        HEAD_EN ? 32'd100 : 32'd0);
        chk("pkt4_pkt",      32'(bus.pkt_count_o), 32'd1);
        step();
        chk("pkt4_drained",  32'(bus.tx_o),        32'd0);
        idle();
        bus.ts_pop_i = 1'b1;
        step();
        bus.ts_pop_i = 1'b0;
        chk("pkt4_popped_valid", 32'(bus.ts_valid_o),  32'd0);
        chk("pkt4_popped_pkt",   32'(bus.pkt_count_o), 32'd0);
        chk("pkt4_popped_ts",    bus.ts_o,             32'd0);

        // --- flit FIFO full, then ack with a simultaneous rx ----------------
        for (int i = 0; i < 16; i++) begin
            send(32'h1000 + 32'(i), 1'b0, 32'd0);
            step();
        end
        chk("full_credit", 32'(bus.credit_o), 32'd0);
        chk("full_head",   bus.data_o,        32'h1000);
        bus.data_i = 32'hDEAD;
        bus.ack_i  = 1'b1;
        step();
        chk("full_ack_credit", 32'(bus.credit_o), 32'd1);
        chk("full_ack_head",   bus.data_o,        32'h1001);
        bus.rx_i  = 1'b0;
        bus.ack_i = 1'b0;
        step();
        chk("cnt15_hold_credit", 32'(bus.credit_o), 32'd1);
        chk("cnt15_hold_head",   bus.data_o,        32'h1001);
        send(32'hBEEF, 1'b0, 32'd0);
        step();
        bus.rx_i = 1'b0;
        chk("refull_credit", 32'(bus.credit_o), 32'd0);
        bus.ack_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 32'h1001 + 32'(i) : 32'hBEEF;
            chk("drain_order", bus.data_o, exp_d);
            step();
        end
        idle();
        chk("drain_empty", 32'(bus.tx_o), 32'd0);

        // --- four single-flit packets fill the stamp queue -------------------
        // Flit 0x1000.. stream above never had an EOP, so its partial packet
        // is still open; close it is not needed because these are fresh
        // packets only with the head queue, which starts each after an EOP.
        // (The open packet's first tick was 0; the first EOP below closes it.)
        for (int i = 0; i < 4; i++) begin
            send(32'h200 + 32'(i), 1'b1, 32'd200 + 32'(i));
            step();
        end
        idle();
        chk("tsq_full_pkt",    32'(bus.pkt_count_o), 32'd4);
        chk("tsq_full_credit", 32'(bus.credit_o),    32'd0);
        chk("tsq_full_tx",     32'(bus.tx_o),        32'd1);
        chk("tsq_full_ts",     bus.ts_o,             32'd200);
        bus.ts_pop_i = 1'b1;
        step();
        bus.ts_pop_i = 1'b0;
        chk("tsq_pop1_pkt",    32'(bus.pkt_count_o), 32'd3);
        chk("tsq_pop1_credit", 32'(bus.credit_o),    32'd1);
        chk("tsq_pop1_ts",     bus.ts_o,             32'd201);
        chk("tsq_pop1_head",   bus.ts_head_o,        HEAD_EN ? 32'd201 : 32'd0);
        bus.ts_pop_i = 1'b1;
        step();
        bus.ts_pop_i = 1'b0;
        chk("tsq_pop2_pkt", 32'(bus.pkt_count_o), 32'd2);
        chk("tsq_pop2_ts",  bus.ts_o,             32'd202);

        // --- EOP push and stamp pop in the same cycle at ts_count=2 ----------
        send(32'h204, 1'b1, 32'd204);
        bus.ts_pop_i = 1'b1;
        step();
        idle();
        chk("pushpop_pkt",  32'(bus.pkt_count_o), 32'd2);
        chk("pushpop_ts",   bus.ts_o,             32'd203);
        bus.ts_pop_i = 1'b1;
        step();
        chk("pushpop_next_ts",   bus.ts_o,      32'd204);
        chk("pushpop_next_head", bus.ts_head_o, HEAD_EN ? 32'd204 : 32'd0);
        step();
        bus.ts_pop_i = 1'b0;
        chk("pushpop_drained", 32'(bus.ts_valid_o), 32'd0);
        bus.ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("pkts_flit_order", bus.data_o, 32'h200 + 32'(i));
            step();
        end
        bus.ack_i = 1'b0;
        chk("pkts_flit_empty", 32'(bus.tx_o), 32'd0);

        // --- pops while empty are ignored -----------------------------------
        bus.ack_i    = 1'b1;
        bus.ts_pop_i = 1'b1;
        step();
        idle();
        chk("empty_pop_pkt",      32'(bus.pkt_count_o), 32'd0);
        chk("empty_pop_ts_valid", 32'(bus.ts_valid_o),  32'd0);
        chk("empty_pop_tx",       32'(bus.tx_o),        32'd0);
        chk("empty_pop_credit",   32'(bus.credit_o),    32'd1);
        chk("empty_pop_data",     bus.data_o,           32'd0);
        send(32'h300, 1'b1, 32'd300);
        step();
        idle();
        chk("after_empty_pkt",  32'(bus.pkt_count_o), 32'd1);
        chk("after_empty_ts",   bus.ts_o,             32'd300);
        chk("after_empty_head", bus.ts_head_o,        HEAD_EN ? 32'd300 : 32'd0);
        chk("after_empty_data", bus.data_o,           32'h300);
        chk("after_empty_eop",  32'(bus.eop_o),       32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
